blood_donor_scanner: RTL
========================

Name: blood_donor_scanner

Overview:
- Sequential companion to the combinational recipient check on the EGO1 board.
- Takes the donor blood type from the switches and, on a start edge, scans all four recipient types one at a time.
- Builds a mask of recipients that may receive the donor's blood and shows scan progress and result on the LEDs.
- Top-level board block, driven by the 100 MHz board clock.

Parameters:
- DWELL_CYCLES, 100_000_000, clock cycles spent on each recipient type (1 s at 100 MHz); must be ≥ 2; benches use 4.

Ports:
- clk  input  1  board clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start_pin  input  1  scan request, level from a button; only the rising edge is used.
- sw_pin  input  8  donor type code = {sw_pin[0], sw_pin[1]}; sw_pin[7:2] unused.
- led_pin  output  16  status and result display, registered.

Behaviour:
- Type code: 2'b00 = A, 2'b01 = B, 2'b10 = O, 2'b11 = AB.
- Compatibility: compat(d, r) = (d == O) | (r == AB) | (d == r).
- Edge detect:
  - start_q is start_pin registered every cycle.
  - start_edge = start_pin & ~start_q.
- State machine: IDLE, SCAN, DONE.
- Reset (any state, any time): state = IDLE, mask = 0, idx = 0, timer = 0, donor = 0, start_q = 0, led_pin = 16'h0000.
- IDLE or DONE with start_edge:
  - donor <= {sw_pin[0], sw_pin[1]}; mask <= 0; idx <= 0; timer <= 0; state <= SCAN.
  - Only one cycle from edge to busy.
- SCAN, every cycle:
  - timer <= timer + 1.
  - When timer == DWELL_CYCLES-1: mask[idx] <= compat(donor, idx); timer <= 0.
  - If idx == 3 at that point, go to DONE; otherwise idx <= idx + 1.
- In SCAN, start_edge and sw_pin changes are ignored; the donor stays latched.
- DONE holds the mask until the next start_edge or rst.
- Latency: mask bit k is written at the end of cycle (k+1)·DWELL_CYCLES after SCAN entry; DONE is entered 4·DWELL_CYCLES cycles after SCAN entry.
- led_pin mapping (all bits registered from state, so they change one cycle after the state change):
  - [3:0] mask, bit k = recipient type k.
  - [7:4] one-hot idx while in SCAN, 0 otherwise.
  - [8] busy (state == SCAN).
  - [9] done (state == DONE).
  - [15:10] zero, except as listed under Optional Feature.
- Start held high continuously produces only one scan. A release followed by a re-press in DONE rescans.

Optional Feature:
- Macro: BLOOD_MATCH_COUNT_EN.
- Defined: led_pin[12:10] shows the number of set mask bits (0–4) as binary. It updates in the same cycle as the mask and is cleared on rst and on scan start.
- Undefined: led_pin[12:10] is tied to 0 and no counter logic is built.

Decomposition:
- Package blood_type_pkg holds:
  - the 2-bit enum bt_t (BT_A, BT_B, BT_O, BT_AB);
  - the state enum (ST_IDLE, ST_SCAN, ST_DONE);
  - a pure function compat(bt_t donor, bt_t recipient);
  - LED bit-index constants.
- One sub-module, dwell_timer:
  - parameter DWELL_CYCLES;
  - inputs clk, rst, clr, en;
  - output tick, high for one cycle when count == DWELL_CYCLES-1.
- The top level owns the FSM, the mask and the LED register.

Test Plan (DWELL_CYCLES = 4):
- Donor O (sw_pin[0]=1, sw_pin[1]=0), pulse start_pin → led_pin[8]=1 for 16 cycles, then led_pin[3:0]=4'b1111, led_pin[9]=1, count = 4 when the macro is defined.
- Donor AB (sw_pin[1:0]=2'b11) → final mask 4'b1000, count = 1. During the scan, led_pin[7:4] steps 0001 → 0010 → 0100 → 1000, 4 cycles each.
- Donor A (sw_pin[0]=0, sw_pin[1]=0) → mask 4'b1001; donor B (sw_pin[0]=0, sw_pin[1]=1) → mask 4'b1010.
- Donor A start, then at cycle 6 set the switches to O and pulse start again → both ignored; final mask is 4'b1001; start held high for 40 cycles yields exactly one scan.
- Assert rst at SCAN cycle 9 → next cycle led_pin = 16'h0000 and state IDLE. A new start afterwards completes a normal 16-cycle scan.
- From DONE, change the switches to B and pulse start → mask clears to 0 the next cycle, then rescans and ends at 4'b1010.

Source files
------------

// File: rtl/blood_type_pkg.sv
// rtl/blood_type_pkg.sv - blood type, scanner state and LED layout definitions
package blood_type_pkg;

    typedef enum logic [1:0] {
        BT_A  = 2'b00,
        BT_B  = 2'b01,
        BT_O  = 2'b10,
        BT_AB = 2'b11
    } bt_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int LED_MASK_LSB = 0;
    localparam int LED_IDX_LSB  = 4;
    localparam int LED_BUSY     = 8;
    localparam int LED_DONE     = 9;
    localparam int LED_CNT_LSB  = 10;

    function automatic logic compat(bt_t donor, bt_t recipient);
        return (donor == BT_O) || (recipient == BT_AB) || (donor == recipient);
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - per-recipient dwell counter, pulses tick on its last count
module dwell_timer #(
    parameter int DWELL_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(DWELL_CYCLES - 1);

    logic [W-1:0] count;

    assign tick = en & (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/blood_donor_scanner.sv
// rtl/blood_donor_scanner.sv - sequential donor/recipient scan with LED status; option BLOOD_MATCH_COUNT_EN
module blood_donor_scanner
    import blood_type_pkg::*;
#(
    parameter int DWELL_CYCLES = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_pin,
    input  logic [7:0]  sw_pin,
    output logic [15:0] led_pin
);

    state_t      state;
    bt_t         donor;
    logic [3:0]  mask;
    logic [1:0]  idx;
    logic        start_q;
    logic        start_edge;
    logic        accept;
    logic        tick;
    logic        hit;
    logic [15:0] led_next;
    logic        unused_sw;

    assign unused_sw  = ^sw_pin[7:2];
    assign start_edge = start_pin & ~start_q;
    // A start edge during a scan is dropped, so the timer only restarts on an accepted start.
    assign accept     = start_edge & (state != ST_SCAN);
    assign hit        = compat(donor, bt_t'(idx));

    dwell_timer #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) u_dwell_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   (state == ST_SCAN),
        .tick (tick)
    );

`ifdef BLOOD_MATCH_COUNT_EN
    logic [2:0] match_cnt;

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            match_cnt <= '0;
        end else if (state == ST_SCAN && tick) begin
            match_cnt <= match_cnt + {2'b00, hit};
        end
    end
`endif

    always_comb begin
        led_next = '0;
        led_next[LED_MASK_LSB +: 4] = mask;
        if (state == ST_SCAN) begin
            led_next[LED_IDX_LSB + int'(idx)] = 1'b1;
        end
        led_next[LED_BUSY] = (state == ST_SCAN);
        led_next[LED_DONE] = (state == ST_DONE);
`ifdef BLOOD_MATCH_COUNT_EN
        led_next[LED_CNT_LSB +: 3] = match_cnt;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            donor   <= BT_A;
            mask    <= '0;
            idx     <= '0;
            start_q <= 1'b0;
            led_pin <= '0;
        end else begin
            start_q <= start_pin;
            led_pin <= led_next;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_edge) begin
                        donor <= bt_t'({sw_pin[0], sw_pin[1]});
                        mask  <= '0;
                        idx   <= '0;
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (tick) begin
                        mask[idx] <= hit;
                        if (idx == 2'd3) begin
                            state <= ST_DONE;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
